// File: rtl/shift_unit.sv
// Iterative logical shifter for MCPU LSL/LSR: moves one bit per clock and
// returns result/carry/zero with a single-cycle done pulse.
module shift_unit #(
    parameter int WORD_SIZE = 8,
    parameter int CNT_SIZE  = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 dir,
    input  logic [WORD_SIZE-1:0] operand,
    input  logic [WORD_SIZE-1:0] amount,
    output logic                 busy,
    output logic                 done,
    output logic [WORD_SIZE-1:0] result,
    output logic                 carry,
    output logic                 zero,
    output logic [1:0]           dbg_state
);

    // start/operand/amount/dir are only looked at on an accepting edge
    // (IDLE or DONE); start seen during SHIFT is dropped, never queued.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_e;

    localparam logic [WORD_SIZE-1:0] AMT_MAX = WORD_SIZE'(WORD_SIZE);
    localparam logic [CNT_SIZE-1:0]  CNT_MAX = CNT_SIZE'(WORD_SIZE);

    state_e               state_q, state_d;
    logic [WORD_SIZE-1:0] res_q, res_d;
    logic [CNT_SIZE-1:0]  cnt_q, cnt_d;
    logic                 carry_q, carry_d;
    logic                 zero_q, zero_d;
    logic                 dir_q, dir_d;
    logic                 over_q, over_d;
    logic                 accept;

    assign accept = start && ((state_q == S_IDLE) || (state_q == S_DONE));

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_SHIFT;
            S_SHIFT: if (cnt_q == '0) state_d = S_DONE;
            S_DONE:  state_d = start ? S_SHIFT : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_q == S_SHIFT);
        done      = (state_q == S_DONE);
        dbg_state = state_q;
    end

    // Amounts above WORD_SIZE clamp the count; the over flag then forces
    // carry to 0 on completion since every real bit has been shifted out.
    always_comb begin
        res_d   = res_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        zero_d  = zero_q;
        dir_d   = dir_q;
        over_d  = over_q;
        if (accept) begin
            res_d   = operand;
            dir_d   = dir;
            over_d  = (amount > AMT_MAX);
            cnt_d   = (amount > AMT_MAX) ? CNT_MAX : CNT_SIZE'(amount);
            carry_d = 1'b0;
            zero_d  = 1'b0;
        end else if (state_q == S_SHIFT) begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - 1'b1;
                if (dir_q) begin
                    {res_d, carry_d} = {1'b0, res_q};
                end else begin
                    {carry_d, res_d} = {res_q, 1'b0};
                end
            end else begin
                zero_d = (res_q == '0);
                if (over_q) carry_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            res_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
            dir_q   <= 1'b0;
            over_q  <= 1'b0;
        end else begin
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            zero_q  <= zero_d;
            dir_q   <= dir_d;
            over_q  <= over_d;
        end
    end

    assign result = res_q;
    assign carry  = carry_q;
    assign zero   = zero_q;

endmodule

// File: tb/tb_shift_unit.sv
// Directed bench for shift_unit: latency, result/carry/zero, handshake and
// reset-abort checks against hand-computed values.
module tb_shift_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       dir;
    logic [7:0] operand;
    logic [7:0] amount;
    logic       busy;
    logic       done;
    logic [7:0] result;
    logic       carry;
    logic       zero;
    logic [1:0] dbg_state;

    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    shift_unit #(.WORD_SIZE(8), .CNT_SIZE(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .dir       (dir),
        .operand   (operand),
        .amount    (amount),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .carry     (carry),
        .zero      (zero),
        .dbg_state (dbg_state)
    );

    // Called at a negedge; returns at the negedge right after the start edge.
    task automatic issue(input logic [7:0] op, input logic [7:0] amt, input logic d);
        start   = 1'b1;
        operand = op;
        amount  = amt;
        dir     = d;
        @(posedge clk);
        @(negedge clk);
        start   = 1'b0;
        operand = 8'hA5;
        amount  = 8'h03;
        dir     = ~d;
    endtask

    // lat = number of edges after the start edge until done is seen; -1 on timeout.
    task automatic wait_done(input int k0, output int lat, output int busy_cycles);
        lat = -1;
        busy_cycles = 0;
        for (int k = k0; k < 30; k++) begin
            if (done) begin
                lat = k;
                break;
            end
            if (busy) busy_cycles++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b1; operand = 8'd41; amount = 8'd1; dir = 1'b0;
        repeat (2) @(negedge clk);
        vec_cnt++;
        if ({busy, done, result, carry, zero} !== 12'h000) begin
            err_cnt++;
            $display("FAIL reset_outputs: got busy=%b done=%b result=%0d carry=%b zero=%b, want all 0",
                     busy, done, result, carry, zero);
        end
        vec_cnt++;
        if (dbg_state !== 2'd0) begin
            err_cnt++;
            $display("FAIL reset_state: got %0d want 0", dbg_state);
        end
        reset = 1'b1; start = 1'b0;
        repeat (2) @(negedge clk);
        vec_cnt++;
        if ({busy, done, result, carry, zero} !== 12'h000 || dbg_state !== 2'd0) begin
            err_cnt++;
            $display("FAIL idle_after_reset: got busy=%b done=%b result=%0d state=%0d, want 0/0/0/0",
                     busy, done, result, dbg_state);
        end
    endtask

    task automatic run_check(input string name, input logic [7:0] op, input logic [7:0] amt,
                             input logic d, input logic [7:0] exp_res, input logic exp_c,
                             input logic exp_z, input int exp_lat);
        int lat, bc;
        issue(op, amt, d);
        wait_done(0, lat, bc);
        vec_cnt++;
        if (lat !== exp_lat) begin
            err_cnt++;
            $display("FAIL %s_latency: got %0d want %0d", name, lat, exp_lat);
        end
        vec_cnt++;
        if (bc !== exp_lat) begin
            err_cnt++;
            $display("FAIL %s_busy_cycles: got %0d want %0d", name, bc, exp_lat);
        end
        vec_cnt++;
        if (result !== exp_res || carry !== exp_c || zero !== exp_z) begin
            err_cnt++;
            $display("FAIL %s_outputs: got result=%0d carry=%b zero=%b want result=%0d carry=%b zero=%b",
                     name, result, carry, zero, exp_res, exp_c, exp_z);
        end
        @(negedge clk);
        vec_cnt++;
        if (done !== 1'b0 || dbg_state !== 2'd0 || result !== exp_res) begin
            err_cnt++;
            $display("FAIL %s_hold_idle: got done=%b state=%0d result=%0d want 0/0/%0d",
                     name, done, dbg_state, result, exp_res);
        end
    endtask

    task automatic test_lsl();
        run_check("lsl_26_2", 8'd26, 8'd2, 1'b0, 8'd104, 1'b0, 1'b0, 3);
        run_check("lsl_41_3", 8'd41, 8'd3, 1'b0, 8'd72, 1'b1, 1'b0, 4);
    endtask

    task automatic test_lsr();
        run_check("lsr_41_1", 8'd41, 8'd1, 1'b1, 8'd20, 1'b1, 1'b0, 2);
        run_check("lsr_26_4", 8'd26, 8'd4, 1'b1, 8'd1, 1'b1, 1'b0, 5);
    endtask

    task automatic test_boundaries();
        run_check("amt0", 8'd41, 8'd0, 1'b0, 8'd41, 1'b0, 1'b0, 1);
        run_check("lsl_amt8", 8'd41, 8'd8, 1'b0, 8'd0, 1'b1, 1'b1, 9);
        run_check("lsr_amt8", 8'h80, 8'd8, 1'b1, 8'd0, 1'b1, 1'b1, 9);
        run_check("lsl_amt9", 8'd41, 8'd9, 1'b0, 8'd0, 1'b0, 1'b1, 9);
        run_check("lsr_amt255", 8'hFF, 8'd255, 1'b1, 8'd0, 1'b0, 1'b1, 9);
    endtask

    task automatic test_back_to_back();
        int lat, bc;
        issue(8'd41, 8'd3, 1'b0);
        @(negedge clk);
        start = 1'b1; operand = 8'd26; amount = 8'd1; dir = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(2, lat, bc);
        vec_cnt++;
        if (lat !== 4 || result !== 8'd72 || carry !== 1'b1) begin
            err_cnt++;
            $display("FAIL start_mid_shift: got lat=%0d result=%0d carry=%b want 4/72/1",
                     lat, result, carry);
        end
        issue(8'd26, 8'd1, 1'b0);
        vec_cnt++;
        if (busy !== 1'b1 || done !== 1'b0 || dbg_state !== 2'd1) begin
            err_cnt++;
            $display("FAIL b2b_accept: got busy=%b done=%b state=%0d want 1/0/1",
                     busy, done, dbg_state);
        end
        wait_done(0, lat, bc);
        vec_cnt++;
        if (lat !== 2 || result !== 8'd52 || carry !== 1'b0 || zero !== 1'b0) begin
            err_cnt++;
            $display("FAIL b2b_result: got lat=%0d result=%0d carry=%b zero=%b want 2/52/0/0",
                     lat, result, carry, zero);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_abort();
        int lat, bc;
        int seen_done;
        issue(8'd41, 8'd5, 1'b0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        vec_cnt++;
        if ({busy, done, result, carry, zero} !== 12'h000 || dbg_state !== 2'd0) begin
            err_cnt++;
            $display("FAIL abort_reset: got busy=%b done=%b result=%0d carry=%b zero=%b state=%0d want all 0",
                     busy, done, result, carry, zero, dbg_state);
        end
        reset = 1'b1;
        seen_done = 0;
        repeat (8) begin
            @(negedge clk);
            if (done || busy) seen_done++;
        end
        vec_cnt++;
        if (seen_done !== 0) begin
            err_cnt++;
            $display("FAIL abort_no_done: got %0d busy/done cycles want 0", seen_done);
        end
        issue(8'd26, 8'd1, 1'b1);
        wait_done(0, lat, bc);
        vec_cnt++;
        if (lat !== 2 || result !== 8'd13 || carry !== 1'b0 || zero !== 1'b0) begin
            err_cnt++;
            $display("FAIL after_abort: got lat=%0d result=%0d carry=%b zero=%b want 2/13/0/0",
                     lat, result, carry, zero);
        end
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; dir = 1'b0; operand = '0; amount = '0;
        @(negedge clk);
        test_reset();
        test_lsl();
        test_lsr();
        test_boundaries();
        test_back_to_back();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/shift_unit.md
Name: shift_unit

Overview:
- Iterative multi-cycle logical shifter: the execute-stage resource that MCPU drives for OP_LSL / OP_LSR.
- The control unit presents the source register value, the shift-amount register value and a direction, then pulses start.
- The unit shifts one bit per clock and returns result, carry and zero with a one-cycle done pulse; MCPU writes the result back to the destination register on done.

Parameters:
- WORD_SIZE, 8, data width of operand, amount and result (matches register file word).
- CNT_SIZE, 4, width of internal shift counter; must hold WORD_SIZE (ceil(log2(WORD_SIZE+1))).

Ports:
- clk  input  1  system clock, rising-edge active.
- reset  input  1  synchronous, active-low reset: sampled on rising clk edge, 0 = reset.
- start  input  1  request pulse; sampled only when accepting (state IDLE or DONE).
- dir  input  1  0 = LSL (shift toward MSB), 1 = LSR (shift toward LSB); zero fill both ways.
- operand  input  WORD_SIZE  value to shift (Rsrc).
- amount  input  WORD_SIZE  shift distance (Rshamt), unsigned.
- busy  output  1  high while state SHIFT.
- done  output  1  one-cycle pulse: result/carry/zero valid and final.
- result  output  WORD_SIZE  shifted value; held from done until next accepted start.
- carry  output  1  last bit shifted out; 0 if amount 0 or amount > WORD_SIZE.
- zero  output  1  result == 0, valid with done and held.

Behaviour:
- Reset (reset==0 at edge): state IDLE; busy=0, done=0, result=0, carry=0, zero=0, counter=0. Reset overrides start and aborts any shift in progress; no done is produced for an aborted operation.
- States: IDLE, SHIFT, DONE.
- IDLE: start=1 at edge → latch operand into result register, dir into dir register, count=min(amount, WORD_SIZE), set over flag = (amount > WORD_SIZE), carry=0; go SHIFT. start=0 → stay.
- SHIFT (busy=1): if count != 0 → one-bit shift, count=count-1.
  - LSL: carry=result[MSB], result={result[MSB-1:0],0}.
  - LSR: carry=result[0], result={0,result[MSB:1]}.
- SHIFT with count == 0 → go DONE; zero=(result==0); if over flag, carry=0.
- DONE: done=1 for exactly this cycle, busy=0.
  - start=1 at edge → accept a new operation exactly as from IDLE (back-to-back issue, no bubble).
  - start=0 at edge → IDLE.
- Inputs are sampled only at the accepting edge; changes on operand/amount/dir while busy have no effect.
- start while SHIFT: ignored, not queued.
- Latency: start sampled at edge E0; done high in the cycle following edge E(n+1), where n=min(amount, WORD_SIZE). amount=0 → done after E1, with result=operand and carry=0.
- amount >= WORD_SIZE: result=0.
  - amount == WORD_SIZE: carry = operand[0] for LSL, operand[MSB] for LSR.
  - amount > WORD_SIZE: carry=0.
  - Latency is clamped at WORD_SIZE+1 cycles.
- Only the full WORD_SIZE amount value is used; no modulo on the amount.
- result, carry and zero are registered outputs; no combinational path from inputs to outputs.

Test Plan:
- Reset then idle: hold reset=0 for 2 cycles, start=1 during reset → all outputs 0, no busy/done; release reset, start=0 → outputs remain 0.
- LSL basic: operand=26, amount=2, dir=0 → busy for 3 cycles, done at cycle 3 after start edge, result=104, carry=0, zero=0; then operand=41, amount=3 → result=72 (0x48), carry=1.
- LSR basic: operand=41, amount=1, dir=1 → result=20, carry=1, done after 2 cycles; operand=26, amount=4 → result=1, carry=1.
- Boundaries:
  - operand=41, amount=0 → result=41, carry=0, done after 1 cycle.
  - LSL amount=8 → result=0, carry=1, zero=1, done after 9 cycles.
  - amount=9 → result=0, carry=0, zero=1, done after 9 cycles.
- Handshake: assert start with new inputs mid-SHIFT → ignored, first result unchanged. Assert start in the DONE cycle (26 LSL 1) → accepted with no idle cycle, result=52.
- Reset mid-operation: start 41 LSL 5, drive reset=0 on the 3rd SHIFT cycle → next edge all outputs 0 and state IDLE, no done pulse. Subsequent 26 LSR 1 → result=13, carry=0.
